// File: rtl/cmd_cntrl.sv
// Command controller: accepts GO/STOP bytes, tracks a destination ID, flags arrival
// on a matching barcode ID and drives an obstacle buzzer while stalled in transit.
module cmd_cntrl #(
  parameter int BUZZ_HALF = 12500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] cmd,
  input  logic       cmd_rdy,
  input  logic [7:0] ID,
  input  logic       ID_vld,
  input  logic       OK2Move,
  output logic       clr_cmd_rdy,
  output logic       clr_ID_vld,
  output logic       in_transit,
  output logic       go,
  output logic       buzz,
  output logic       buzz_n,
  output logic       arrived
);

  typedef enum logic {IDLE, TRANSIT} state_t;

  localparam logic [1:0]  OP_STOP  = 2'b00;
  localparam logic [1:0]  OP_GO    = 2'b01;
  localparam logic [13:0] BUZZ_MAX = 14'(BUZZ_HALF - 1);

  state_t      r_state, w_state_nxt;
  logic [5:0]  r_dest, w_dest_nxt;
  logic        r_clr_cmd, w_clr_cmd_nxt;
  logic        r_clr_id, w_clr_id_nxt;
  logic        r_arrived, w_arrived_nxt;
  logic [13:0] r_buzz_cnt;
  logic        r_buzz;
  logic        w_cmd_take, w_id_take, w_buzz_run;

  // An input whose clear pulse is already out is still high this cycle; mask it.
  assign w_cmd_take = cmd_rdy & ~r_clr_cmd;
  assign w_id_take  = ID_vld & ~r_clr_id & ~w_cmd_take;
  assign w_buzz_run = (r_state == TRANSIT) & ~OK2Move;

  always_comb begin
    w_state_nxt   = r_state;
    w_dest_nxt    = r_dest;
    w_clr_cmd_nxt = 1'b0;
    w_clr_id_nxt  = 1'b0;
    w_arrived_nxt = 1'b0;
    if (w_cmd_take) begin
      w_clr_cmd_nxt = 1'b1;
      if (cmd[7:6] == OP_GO) begin
        w_dest_nxt  = cmd[5:0];
        w_state_nxt = TRANSIT;
      end else if (cmd[7:6] == OP_STOP) begin
        w_state_nxt = IDLE;
      end
    end else if (w_id_take) begin
      w_clr_id_nxt = 1'b1;
      if ((r_state == TRANSIT) && (ID[7:6] == 2'b00) && (ID[5:0] == r_dest)) begin
        w_arrived_nxt = 1'b1;
        w_state_nxt   = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_dest     <= 6'd0;
      r_clr_cmd  <= 1'b0;
      r_clr_id   <= 1'b0;
      r_arrived  <= 1'b0;
      r_buzz_cnt <= 14'd0;
      r_buzz     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dest    <= w_dest_nxt;
      r_clr_cmd <= w_clr_cmd_nxt;
      r_clr_id  <= w_clr_id_nxt;
      r_arrived <= w_arrived_nxt;
      if (!w_buzz_run) begin
        r_buzz_cnt <= 14'd0;
        r_buzz     <= 1'b0;
      end else if (r_buzz_cnt == BUZZ_MAX) begin
        r_buzz_cnt <= 14'd0;
        r_buzz     <= ~r_buzz;
      end else begin
        r_buzz_cnt <= r_buzz_cnt + 14'd1;
      end
    end
  end

  assign in_transit  = (r_state == TRANSIT);
  assign go          = in_transit & OK2Move;
  assign buzz        = r_buzz;
  assign buzz_n      = ~r_buzz;
  assign clr_cmd_rdy = r_clr_cmd;
  assign clr_ID_vld  = r_clr_id;
  assign arrived     = r_arrived;

endmodule

// File: tb/tb_cmd_cntrl.sv
// Self-checking bench for cmd_cntrl: per-cycle vector table plus buzzer and
// reset sequences, with expected outputs queued at drive time and checked after the edge.
module tb_cmd_cntrl;

  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic [7:0] ID;
  logic       ID_vld;
  logic       OK2Move;
  logic       clr_cmd_rdy, clr_ID_vld, in_transit, go, buzz, buzz_n, arrived;

  cmd_cntrl #(.BUZZ_HALF(BH)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .ID(ID), .ID_vld(ID_vld),
    .OK2Move(OK2Move), .clr_cmd_rdy(clr_cmd_rdy), .clr_ID_vld(clr_ID_vld),
    .in_transit(in_transit), .go(go), .buzz(buzz), .buzz_n(buzz_n), .arrived(arrived)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       r;
    logic [7:0] c;
    logic       cr;
    logic [7:0] id;
    logic       iv;
    logic       ok;
    logic       it;
    logic       g;
    logic       bz;
    logic       ccr;
    logic       civ;
    logic       arr;
  } vec_t;

  vec_t vt [0:23];
  vec_t exp_q [$];
  int   n_chk  = 0;
  int   n_fail = 0;
  logic prev_it = 1'b0;
  logic have_prev = 1'b0;

  function automatic vec_t mk(logic r, logic [7:0] c, logic cr, logic [7:0] id, logic iv,
                              logic ok, logic it, logic g, logic bz, logic ccr, logic civ,
                              logic arr);
    vec_t v;
    v = '{r, c, cr, id, iv, ok, it, g, bz, ccr, civ, arr};
    return v;
  endfunction

  task automatic chk(input string name, input int step, input logic act, input logic expv);
    n_chk++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s step %0d: got %b expected %b", name, step, act, expv);
    end
  endtask

  task automatic step(input int idx, input vec_t v);
    vec_t e;
    @(negedge clk);
    rst = v.r; cmd = v.c; cmd_rdy = v.cr; ID = v.id; ID_vld = v.iv; OK2Move = v.ok;
    exp_q.push_back(v);
    #1;
    if (have_prev) chk("go_comb", idx, go, prev_it & v.ok);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("in_transit", idx, in_transit, e.it);
    chk("go", idx, go, e.g);
    chk("buzz", idx, buzz, e.bz);
    chk("buzz_n", idx, buzz_n, ~e.bz);
    chk("clr_cmd_rdy", idx, clr_cmd_rdy, e.ccr);
    chk("clr_ID_vld", idx, clr_ID_vld, e.civ);
    chk("arrived", idx, arrived, e.arr);
    prev_it = e.it;
    have_prev = 1'b1;
  endtask

  initial begin
    rst = 1'b1; cmd = 8'h00; cmd_rdy = 1'b0; ID = 8'h00; ID_vld = 1'b0; OK2Move = 1'b1;
    //           r  cmd    cr id     iv ok  it g  bz ccr civ arr
    vt[0]  = mk(1, 8'h00, 0, 8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 8'h42, 1, 8'h00, 0, 1,  1, 1, 0, 1, 0, 0);
    vt[2]  = mk(0, 8'h42, 1, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);
    vt[3]  = mk(0, 8'h00, 0, 8'h05, 1, 1,  1, 1, 0, 0, 1, 0);
    vt[4]  = mk(0, 8'h00, 0, 8'h05, 1, 1,  1, 1, 0, 0, 0, 0);
    vt[5]  = mk(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);
    vt[6]  = mk(0, 8'h00, 0, 8'h02, 1, 1,  0, 0, 0, 0, 1, 1);
    vt[7]  = mk(0, 8'h00, 0, 8'h02, 1, 1,  0, 0, 0, 0, 0, 0);
    vt[8]  = mk(0, 8'h41, 1, 8'h00, 0, 1,  1, 1, 0, 1, 0, 0);
    vt[9]  = mk(0, 8'h41, 1, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);
    vt[10] = mk(0, 8'h00, 1, 8'h00, 0, 1,  0, 0, 0, 1, 0, 0);
    vt[11] = mk(0, 8'h00, 1, 8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
    vt[12] = mk(0, 8'h00, 0, 8'h01, 1, 1,  0, 0, 0, 0, 1, 0);
    vt[13] = mk(0, 8'h00, 0, 8'h01, 1, 1,  0, 0, 0, 0, 0, 0);
    vt[14] = mk(0, 8'hC1, 1, 8'h00, 0, 1,  0, 0, 0, 1, 0, 0);
    vt[15] = mk(0, 8'hC1, 1, 8'h00, 0, 1,  0, 0, 0, 0, 0, 0);
    vt[16] = mk(0, 8'h43, 1, 8'h00, 0, 1,  1, 1, 0, 1, 0, 0);
    vt[17] = mk(0, 8'h43, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);
    vt[18] = mk(0, 8'h44, 1, 8'h03, 1, 1,  1, 1, 0, 1, 0, 0);
    vt[19] = mk(0, 8'h44, 1, 8'h03, 1, 1,  1, 1, 0, 0, 1, 0);
    vt[20] = mk(0, 8'h00, 0, 8'h03, 1, 1,  1, 1, 0, 0, 0, 0);
    vt[21] = mk(0, 8'h80, 1, 8'h00, 0, 1,  1, 1, 0, 1, 0, 0);
    vt[22] = mk(0, 8'h80, 1, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);
    vt[23] = mk(0, 8'h00, 0, 8'h00, 0, 1,  1, 1, 0, 0, 0, 0);

    for (int i = 0; i < 24; i++) step(i, vt[i]);

    // Obstacle in transit: buzz toggles every BH cycles, go held low.
    for (int k = 1; k <= 20; k++)
      step(100 + k, mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1'((k / BH) % 2), 0, 0, 0));
    step(121, mk(0, 8'h00, 0, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));

    // Reset mid-buzz with a pending GO that must survive reset.
    for (int k = 1; k <= 5; k++)
      step(200 + k, mk(0, 8'h00, 0, 8'h00, 0, 0, 1, 0, 1'((k / BH) % 2), 0, 0, 0));
    step(206, mk(1, 8'h42, 1, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0));
    step(207, mk(0, 8'h42, 1, 8'h00, 0, 1, 1, 1, 0, 1, 0, 0));
    step(208, mk(0, 8'h42, 1, 8'h00, 0, 1, 1, 1, 0, 0, 0, 0));
    step(209, mk(0, 8'h00, 0, 8'h02, 1, 1, 0, 0, 0, 0, 1, 1));
    step(210, mk(0, 8'h00, 0, 8'h00, 0, 1, 0, 0, 0, 0, 0, 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_cntrl.md
CMD_CNTRL -- requirements
Module: cmd_cntrl

Interface
REQ-001 Parameter: BUZZ_HALF, default 12500, clk cycles per buzzer half-period (2 kHz at 50 MHz); legal range 2..16383.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 cmd  input  8  UART command byte; [7:6]=opcode (00 STOP, 01 GO, 1x reserved), [5:0]=destination ID.
REQ-005 cmd_rdy  input  1  level; cmd valid until cleared via clr_cmd_rdy.
REQ-006 ID  input  8  barcode station ID; valid only when ID[7:6]=00.
REQ-007 ID_vld  input  1  level; ID valid until cleared via clr_ID_vld.
REQ-008 OK2Move  input  1  proximity OK; 0 = obstacle present.
REQ-009 clr_cmd_rdy  output  1  one-cycle pulse consuming cmd.
REQ-010 clr_ID_vld  output  1  one-cycle pulse consuming ID.
REQ-011 in_transit  output  1  high while travelling toward latched destination.
REQ-012 go  output  1  motor enable = in_transit AND OK2Move.
REQ-013 buzz  output  1  obstacle buzzer drive.
REQ-014 buzz_n  output  1  complement of buzz.
REQ-015 arrived  output  1  one-cycle pulse on destination match.

Function
REQ-016 FSM states: IDLE, TRANSIT; in_transit is registered, high exactly in TRANSIT.
REQ-017 Internal 6-bit dest register, loaded only on GO acceptance.
REQ-018 IDLE, cmd_rdy with GO: load dest=cmd[5:0], pulse clr_cmd_rdy, enter TRANSIT next cycle.
REQ-019 IDLE, cmd_rdy with STOP or reserved opcode: pulse clr_cmd_rdy, stay IDLE, dest unchanged.
REQ-020 IDLE, ID_vld (no cmd_rdy): pulse clr_ID_vld, ignore ID.
REQ-021 TRANSIT, cmd_rdy with STOP: pulse clr_cmd_rdy, enter IDLE next cycle.
REQ-022 TRANSIT, cmd_rdy with GO: reload dest, pulse clr_cmd_rdy, stay TRANSIT.
REQ-023 TRANSIT, cmd_rdy with reserved opcode: pulse clr_cmd_rdy, no other effect.
REQ-024 TRANSIT, ID_vld (no cmd_rdy): pulse clr_ID_vld; if ID[7:6]=00 and ID[5:0]=dest, pulse arrived and enter IDLE next cycle; else stay.
REQ-025 cmd_rdy and ID_vld same cycle: cmd handled that cycle, ID_vld not cleared; ID evaluated next cycle against the post-command state/dest.
REQ-026 clr_cmd_rdy and clr_ID_vld never asserted in same cycle; each pulse is exactly one cycle, registered.
REQ-027 Any input seen while its clear pulse is high is not re-processed that cycle (no double consumption).
REQ-028 go is combinational from registered in_transit and OK2Move; zero-cycle latency from OK2Move.
REQ-029 Buzzer: 14-bit counter runs only while in_transit=1 and OK2Move=0; at count BUZZ_HALF-1, counter wraps to 0 and buzz toggles.
REQ-030 When in_transit=0 or OK2Move=1: counter cleared to 0 and buzz forced 0 the following cycle.
REQ-031 buzz_n = NOT buzz at all times.
REQ-032 Leaving TRANSIT (STOP or arrival) while buzzing: buzz=0 the cycle after in_transit falls.

Reset
REQ-033 rst=1 at rising clk: state=IDLE, dest=0, buzzer counter=0; outputs in_transit=0, go=0, buzz=0, buzz_n=1, clr_cmd_rdy=0, clr_ID_vld=0, arrived=0.
REQ-034 Reset mid-transit or mid-buzz aborts immediately; pending cmd_rdy/ID_vld are not cleared by reset and are processed after release.

Verification
REQ-035 rst, then cmd=8'h42, cmd_rdy -> one clr_cmd_rdy pulse; in_transit=1 next cycle; go=1 with OK2Move=1.
REQ-036 TRANSIT dest=02: ID=8'h05 with ID_vld -> clr_ID_vld pulse, in_transit stays 1, no arrived; then ID=8'h02 -> arrived pulse, in_transit=0 next cycle.
REQ-037 TRANSIT dest=01: cmd=8'h00 -> in_transit=0 next cycle; ID=8'h01 afterwards -> cleared, ignored, no arrived.
REQ-038 BUZZ_HALF=4, TRANSIT, OK2Move=0 for 20 cycles -> go=0 immediately, buzz toggles every 4 cycles, buzz_n inverse; OK2Move=1 -> buzz=0 next cycle, go=1.
REQ-039 TRANSIT dest=03: cmd=8'h44 and ID=8'h03 same cycle -> cmd consumed first, dest=04; ID consumed next cycle, no arrived, still TRANSIT.
REQ-040 cmd=8'hC1 in IDLE -> cleared, stays IDLE; rst asserted mid-buzz -> all outputs to REQ-033 values next edge.
